// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_pkg;

    localparam int HDR_W          = 4;
    localparam int STATE_W        = 128;
    localparam int NUM_ROUNDS_DEF = 10;
    localparam int KEY_IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    // Full packet as seen on the datapath input bus; this block only ever sees the header.
    typedef struct packed {
        logic [HDR_W-1:0]   header;
        logic [STATE_W-1:0] state;
    } aes_pkt_t;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Packet-in / block-out handshake bundle for the AES round sequencer.
interface aes_round_sequencer_if
    import aes_pkg::*;
();
    logic             in_valid;
    logic [HDR_W-1:0] in_header;
    logic             in_ready;
    logic             out_valid;
    logic [HDR_W-1:0] out_header;
    logic             out_ready;

    modport master (
        output in_valid, in_header, out_ready,
        input  in_ready, out_valid, out_header
    );

    modport slave (
        input  in_valid, in_header, out_ready,
        output in_ready, out_valid, out_header
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM stepping one AES-128 block through the iterative round datapath.
// Optional abort input enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef AES_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    aes_round_sequencer_if.slave bus,
    output logic                 busy,
    output logic                 dp_load,
    output logic                 dp_round_en,
    output logic                 dp_mix_bypass,
    output logic [KEY_IDX_W-1:0] dp_key_idx
);

    localparam logic [3:0] LAST_FULL = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FINAL_KEY = 4'(NUM_ROUNDS);

    seq_state_t       state, state_nxt;
    logic [3:0]       rnd, rnd_nxt;
    logic [HDR_W-1:0] hdr, hdr_nxt;

    logic             in_ready;
    logic             out_valid;
    logic [HDR_W-1:0] out_header;
    logic             new_blk;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_header = out_header;
    assign busy           = (state != IDLE);
    assign new_blk        = bus.in_valid && (bus.in_header != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rnd   <= '0;
            hdr   <= '0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            hdr   <= hdr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rnd_nxt       = rnd;
        hdr_nxt       = hdr;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_header    = '0;
        dp_load       = 1'b0;
        dp_round_en   = 1'b0;
        dp_mix_bypass = 1'b0;
        dp_key_idx    = '0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                // A zero header is consumed but starts nothing.
                if (new_blk) begin
                    dp_load   = 1'b1;
                    hdr_nxt   = bus.in_header;
                    rnd_nxt   = 4'd1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                dp_round_en = 1'b1;
                dp_key_idx  = rnd;
                rnd_nxt     = rnd + 4'd1;
                if (rnd == LAST_FULL) state_nxt = FINAL;
            end
            FINAL: begin
                dp_round_en   = 1'b1;
                dp_mix_bypass = 1'b1;
                dp_key_idx    = FINAL_KEY;
                state_nxt     = HOLD;
            end
            HOLD: begin
                out_valid  = 1'b1;
                out_header = hdr;
                in_ready   = bus.out_ready;
                // Retire and accept in the same cycle to keep back-to-back blocks gapless.
                if (bus.out_ready) begin
                    if (new_blk) begin
                        dp_load   = 1'b1;
                        hdr_nxt   = bus.in_header;
                        rnd_nxt   = 4'd1;
                        state_nxt = ROUND;
                    end else begin
                        hdr_nxt   = '0;
                        rnd_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef AES_SEQ_ABORT_EN
        if (abort) begin
            state_nxt     = IDLE;
            rnd_nxt       = '0;
            hdr_nxt       = '0;
            in_ready      = 1'b0;
            out_valid     = 1'b0;
            out_header    = '0;
            dp_load       = 1'b0;
            dp_round_en   = 1'b0;
            dp_mix_bypass = 1'b0;
            dp_key_idx    = '0;
        end
`endif
    end

endmodule
